// File: rtl/lcd_controller.sv
// Write-only HD44780 8-bit bus engine: one RS/DATA/EN write sequence per iStart rising edge.
// The host sequencer owns command ordering, inter-command delays and completion waits.
module lcd_controller #(
  parameter int unsigned EN_CYCLES = 16
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [7:0] iDATA,
  input  logic       iRS,
  input  logic       iStart,
  output logic       oDone,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, FINISH} state_t;

  // PULSE hands over to FINISH one count early, so that the EN fall in FINISH
  // lands after exactly EN_CYCLES high cycles.
  localparam logic [7:0] EN_LAST = 8'(EN_CYCLES - 1);

  state_t     state, state_d;
  logic [7:0] cnt, cnt_d;
  logic       prev;
  logic       en_q, en_d;
  logic       done_q, done_d;
  logic [7:0] data_q, data_d;
  logic       rs_q, rs_d;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state  <= IDLE;
      cnt    <= '0;
      prev   <= 1'b0;
      en_q   <= 1'b0;
      done_q <= 1'b0;
      data_q <= '0;
      rs_q   <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      prev   <= iStart;
      en_q   <= en_d;
      done_q <= done_d;
      data_q <= data_d;
      rs_q   <= rs_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    en_d    = en_q;
    done_d  = done_q;
    data_d  = data_q;
    rs_d    = rs_q;
    case (state)
      IDLE: begin
        if (iStart && !prev) begin
          done_d  = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        data_d  = iDATA;
        rs_d    = iRS;
        cnt_d   = '0;
        state_d = PULSE;
      end
      PULSE: begin
        en_d = 1'b1;
        if (cnt == EN_LAST) begin
          cnt_d   = '0;
          state_d = FINISH;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      FINISH: begin
        en_d    = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign oDone    = done_q;
  assign LCD_DATA = data_q;
  assign LCD_RS   = rs_q;
  assign LCD_EN   = en_q;
  assign LCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_controller.sv
// Directed bench for lcd_controller: default-width instance with a pulse scoreboard,
// plus an EN_CYCLES=1 instance for the minimum-pulse case.
module tb_lcd_controller;

  localparam int unsigned EN0 = 16;

  logic       iCLK = 1'b0;
  logic       iRST;
  logic [7:0] iDATA;
  logic       iRS;
  logic       iStart;
  logic       oDone;
  logic [7:0] LCD_DATA;
  logic       LCD_RW;
  logic       LCD_EN;
  logic       LCD_RS;

  logic [7:0] s1_data;
  logic       s1_rs;
  logic       s1_start;
  logic       d1_done;
  logic [7:0] d1_data;
  logic       d1_rw;
  logic       d1_en;
  logic       d1_rs;

  always #10 iCLK = ~iCLK;

  lcd_controller #(.EN_CYCLES(EN0)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iRS(iRS), .iStart(iStart),
    .oDone(oDone), .LCD_DATA(LCD_DATA), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_RS(LCD_RS)
  );

  lcd_controller #(.EN_CYCLES(1)) dut1 (
    .iCLK(iCLK), .iRST(iRST), .iDATA(s1_data), .iRS(s1_rs), .iStart(s1_start),
    .oDone(d1_done), .LCD_DATA(d1_data), .LCD_RW(d1_rw), .LCD_EN(d1_en), .LCD_RS(d1_rs)
  );

  typedef struct {
    logic [7:0] d;
    logic       rs;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int done_rises = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // Scoreboard side: every completed EN pulse pops one expected write.
  logic en_prev = 1'b0;
  logic done_prev = 1'b0;
  int   width = 0;
  always @(negedge iCLK) begin
    exp_t e;
    check("rw_low", {31'd0, LCD_RW}, 32'd0);
    if (oDone === 1'b1 && done_prev === 1'b0) done_rises++;
    if (LCD_EN === 1'b1) width++;
    if (en_prev === 1'b1 && LCD_EN !== 1'b1) begin
      if (iRST === 1'b1) begin
        if (q.size() > 0) void'(q.pop_front());
      end else begin
        pulses++;
        check("pulse_expected", {31'd0, q.size() != 0}, 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("pulse_data", {24'd0, LCD_DATA}, {24'd0, e.d});
          check("pulse_rs", {31'd0, LCD_RS}, {31'd0, e.rs});
          check("pulse_width", width, EN0);
          check("done_at_en_fall", {31'd0, oDone}, 32'd1);
        end
      end
      width = 0;
    end
    en_prev   = LCD_EN;
    done_prev = oDone;
  end

  // Full-timeline write on the default instance; edge T is the first posedge after the call.
  task automatic write_and_check(input logic [7:0] d, input logic r);
    int n;
    exp_t e;
    e.d = d;
    e.rs = r;
    iDATA = d;
    iRS = r;
    iStart = 1'b1;
    q.push_back(e);
    tick();
    iStart = 1'b0;
    @(negedge iCLK);
    check("done_clear_T", {31'd0, oDone}, 32'd0);
    tick();
    @(negedge iCLK);
    check("data_T1", {24'd0, LCD_DATA}, {24'd0, d});
    check("rs_T1", {31'd0, LCD_RS}, {31'd0, r});
    check("en_low_T1", {31'd0, LCD_EN}, 32'd0);
    tick();
    @(negedge iCLK);
    check("en_high_T2", {31'd0, LCD_EN}, 32'd1);
    n = 2;
    while (oDone !== 1'b1 && n < 200) begin
      tick();
      n++;
      @(negedge iCLK);
    end
    check("done_latency", n, EN0 + 2);
  endtask

  initial begin
    int base_p;
    int base_d;
    exp_t e;
    iRST = 1'b1;
    iDATA = '0;
    iRS = 1'b0;
    iStart = 1'b0;
    s1_data = '0;
    s1_rs = 1'b0;
    s1_start = 1'b0;
    repeat (3) tick();
    @(negedge iCLK);
    check("rst_en", {31'd0, LCD_EN}, 32'd0);
    check("rst_data", {24'd0, LCD_DATA}, 32'd0);
    check("rst_rs", {31'd0, LCD_RS}, 32'd0);
    check("rst_done", {31'd0, oDone}, 32'd0);
    tick();
    iRST = 1'b0;
    repeat (2) tick();

    // Single command write, default width
    write_and_check(8'h38, 1'b0);
    repeat (3) tick();

    // Data write, held after EN fall
    write_and_check(8'h35, 1'b1);
    repeat (4) tick();
    @(negedge iCLK);
    check("data_hold", {24'd0, LCD_DATA}, 32'h35);
    check("rs_hold", {31'd0, LCD_RS}, 32'd1);
    check("done_hold", {31'd0, oDone}, 32'd1);

    // Second rising edge at T+5 while busy is dropped
    base_p = pulses;
    base_d = done_rises;
    e.d = 8'h01;
    e.rs = 1'b0;
    iDATA = 8'h01;
    iRS = 1'b0;
    iStart = 1'b1;
    q.push_back(e);
    tick();
    iStart = 1'b0;
    repeat (4) tick();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    repeat (50) tick();
    @(negedge iCLK);
    check("busy_pulses", pulses - base_p, 1);
    check("busy_dones", done_rises - base_d, 1);

    // Level-held start produces one write
    base_p = pulses;
    e.d = 8'h0E;
    e.rs = 1'b0;
    iDATA = 8'h0E;
    iStart = 1'b1;
    q.push_back(e);
    repeat (100) tick();
    iStart = 1'b0;
    repeat (5) tick();
    @(negedge iCLK);
    check("level_pulses", pulses - base_p, 1);

    // Reset while EN is high aborts the write
    base_p = pulses;
    base_d = done_rises;
    e.d = 8'hA5;
    e.rs = 1'b1;
    iDATA = 8'hA5;
    iRS = 1'b1;
    iStart = 1'b1;
    q.push_back(e);
    tick();
    iStart = 1'b0;
    repeat (6) tick();
    @(negedge iCLK);
    check("mid_en_high", {31'd0, LCD_EN}, 32'd1);
    tick();
    iRST = 1'b1;
    tick();
    @(negedge iCLK);
    check("abort_en", {31'd0, LCD_EN}, 32'd0);
    check("abort_data", {24'd0, LCD_DATA}, 32'd0);
    check("abort_rs", {31'd0, LCD_RS}, 32'd0);
    check("abort_done", {31'd0, oDone}, 32'd0);
    tick();
    iRST = 1'b0;
    repeat (30) tick();
    @(negedge iCLK);
    check("abort_no_pulse", pulses - base_p, 0);
    check("abort_no_done", done_rises - base_d, 0);
    write_and_check(8'h06, 1'b0);
    repeat (3) tick();

    // Minimum pulse width on the EN_CYCLES=1 instance
    s1_data = 8'h0C;
    s1_rs = 1'b0;
    s1_start = 1'b1;
    tick();
    s1_start = 1'b0;
    @(negedge iCLK);
    check("min_done_T", {31'd0, d1_done}, 32'd0);
    tick();
    @(negedge iCLK);
    check("min_data_T1", {24'd0, d1_data}, 32'h0C);
    check("min_en_T1", {31'd0, d1_en}, 32'd0);
    tick();
    @(negedge iCLK);
    check("min_en_T2", {31'd0, d1_en}, 32'd1);
    check("min_done_T2", {31'd0, d1_done}, 32'd0);
    tick();
    @(negedge iCLK);
    check("min_en_T3", {31'd0, d1_en}, 32'd0);
    check("min_done_T3", {31'd0, d1_done}, 32'd1);
    check("min_rw", {31'd0, d1_rw}, 32'd0);

    repeat (3) tick();
    @(negedge iCLK);
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
